// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared encodings and constants for the raster sequencer
package video_timing_pkg;

    localparam int CNT_W = 12;   // raster counter width (totals up to 4095)
    localparam int RES_W = 11;   // configurable active resolution width

    // Phase of one raster axis; the same encoding serves horizontal and vertical
    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_FRONT  = 2'd1,
        ST_SYNC   = 2'd2,
        ST_BACK   = 2'd3
    } phase_e;

    // 1080p60 timing
    localparam int H_FP_1080P  = 88;
    localparam int H_SYNC_1080P = 44;
    localparam int H_BP_1080P  = 148;
    localparam int V_FP_1080P  = 4;
    localparam int V_SYNC_1080P = 5;
    localparam int V_BP_1080P  = 36;
    localparam int H_RES_1080P = 1920;
    localparam int V_RES_1080P = 1080;

endpackage

// File: rtl/timing_axis.sv
// rtl/timing_axis.sv - one raster axis: counter plus ACTIVE/FRONT/SYNC/BACK phase FSM
//
// Ports:
//   clock_i  pixel clock
//   reset_i  asynchronous active-high reset
//   step_i   advance the axis by one position this clock
//   res_i    active length of the axis
//   fp_i     front porch length (must be >= 1)
//   sync_i   sync length (must be >= 1)
//   bp_i     back porch length (must be >= 1)
//   count_o  current position, 0..total-1
//   state_o  current phase
//   wrap_o   high on the step that returns the axis from total-1 to 0
module timing_axis
    import video_timing_pkg::*;
(
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             step_i,
    input  logic [CNT_W-1:0] res_i,
    input  logic [CNT_W-1:0] fp_i,
    input  logic [CNT_W-1:0] sync_i,
    input  logic [CNT_W-1:0] bp_i,
    output logic [CNT_W-1:0] count_o,
    output phase_e           state_o,
    output logic             wrap_o
);

    logic [CNT_W-1:0] count_q, count_d;
    phase_e           state_q, state_d;

    // Last position of each phase; the FSM leaves a phase when the counter hits it.
    logic [CNT_W-1:0] active_end;
    logic [CNT_W-1:0] front_end;
    logic [CNT_W-1:0] sync_end;
    logic [CNT_W-1:0] total_end;

    assign active_end = res_i - CNT_W'(1);
    assign front_end  = active_end + fp_i;
    assign sync_end   = front_end + sync_i;
    assign total_end  = sync_end + bp_i;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
            state_q <= ST_ACTIVE;
        end else begin
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        count_d = count_q;
        state_d = state_q;
        if (step_i) begin
            count_d = count_q + CNT_W'(1);
            unique case (state_q)
                ST_ACTIVE: if (count_q == active_end) state_d = ST_FRONT;
                ST_FRONT:  if (count_q == front_end)  state_d = ST_SYNC;
                ST_SYNC:   if (count_q == sync_end)   state_d = ST_BACK;
                ST_BACK: begin
                    if (count_q == total_end) begin
                        state_d = ST_ACTIVE;
                        count_d = '0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        count_o = count_q;
        state_o = state_q;
        wrap_o  = step_i && (state_q == ST_BACK) && (count_q == total_end);
    end

endmodule

// File: rtl/video_timing_ctrl.sv
// rtl/video_timing_ctrl.sv - raster sequencer with frame-aligned resolution updates
//
// Ports:
//   clock_i            pixel clock
//   reset_i            asynchronous active-high reset
//   enable_i           advance one pixel per clock when high; everything holds when low
//   res_horizontal_i   requested active width (0 = keep current)
//   res_vertical_i     requested active height (0 = keep current)
//   cfg_update_i       capture the requested resolution as pending
//   h_sync_pulse_o     horizontal sync, SYNC_POL when asserted
//   v_sync_pulse_o     vertical sync, SYNC_POL when asserted
//   active_video_o     pixel lies in the active area
//   pixel_x_o          horizontal position of the presented pixel
//   pixel_y_o          vertical position of the presented pixel
//   line_start_o       presented pixel has x == 0
//   frame_start_o      presented pixel has x == 0 and y == 0
module video_timing_ctrl
    import video_timing_pkg::*;
#(
    parameter int   H_FP      = H_FP_1080P,
    parameter int   H_SYNC    = H_SYNC_1080P,
    parameter int   H_BP      = H_BP_1080P,
    parameter int   V_FP      = V_FP_1080P,
    parameter int   V_SYNC    = V_SYNC_1080P,
    parameter int   V_BP      = V_BP_1080P,
    parameter int   H_RES_DEF = H_RES_1080P,
    parameter int   V_RES_DEF = V_RES_1080P,
    parameter logic SYNC_POL  = 1'b1
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic [RES_W-1:0] res_horizontal_i,
    input  logic [RES_W-1:0] res_vertical_i,
    input  logic             cfg_update_i,
    output logic             h_sync_pulse_o,
    output logic             v_sync_pulse_o,
    output logic             active_video_o,
    output logic [CNT_W-1:0] pixel_x_o,
    output logic [CNT_W-1:0] pixel_y_o,
    output logic             line_start_o,
    output logic             frame_start_o
);

    // Resolution shadowing
    logic [RES_W-1:0] h_res_q, h_res_d;
    logic [RES_W-1:0] v_res_q, v_res_d;
    logic [RES_W-1:0] pend_h_q, pend_h_d;
    logic [RES_W-1:0] pend_v_q, pend_v_d;
    logic             pend_valid_q, pend_valid_d;

    // Axis state
    logic [CNT_W-1:0] h_count, v_count;
    phase_e           h_state, v_state;
    logic             h_wrap, v_wrap;

    timing_axis u_h_axis (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .step_i  (enable_i),
        .res_i   ({1'b0, h_res_q}),
        .fp_i    (CNT_W'(H_FP)),
        .sync_i  (CNT_W'(H_SYNC)),
        .bp_i    (CNT_W'(H_BP)),
        .count_o (h_count),
        .state_o (h_state),
        .wrap_o  (h_wrap)
    );

    // The vertical axis only moves when a line completes; its wrap is the frame wrap.
    timing_axis u_v_axis (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .step_i  (h_wrap),
        .res_i   ({1'b0, v_res_q}),
        .fp_i    (CNT_W'(V_FP)),
        .sync_i  (CNT_W'(V_SYNC)),
        .bp_i    (CNT_W'(V_BP)),
        .count_o (v_count),
        .state_o (v_state),
        .wrap_o  (v_wrap)
    );

    // A capture on the wrap clock is folded in before the apply decision so that
    // it takes effect in the frame beginning on that same edge. Both axes sit at
    // their last position on the wrap, so changing res here never tears a frame.
    always_comb begin
        pend_h_d     = cfg_update_i ? res_horizontal_i : pend_h_q;
        pend_v_d     = cfg_update_i ? res_vertical_i   : pend_v_q;
        pend_valid_d = cfg_update_i | pend_valid_q;
        h_res_d      = h_res_q;
        v_res_d      = v_res_q;
        if (v_wrap && pend_valid_d) begin
            if (pend_h_d != '0) h_res_d = pend_h_d;
            if (pend_v_d != '0) v_res_d = pend_v_d;
            pend_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            h_res_q      <= RES_W'(H_RES_DEF);
            v_res_q      <= RES_W'(V_RES_DEF);
            pend_h_q     <= '0;
            pend_v_q     <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            h_res_q      <= h_res_d;
            v_res_q      <= v_res_d;
            pend_h_q     <= pend_h_d;
            pend_v_q     <= pend_v_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    // Output decode: registered from the counters, so every output describes the
    // pixel the counters held on the previous enabled clock.
    logic             h_sync_d, v_sync_d, active_d, line_start_d, frame_start_d;
    logic             h_sync_q, v_sync_q, active_q, line_start_q, frame_start_q;
    logic [CNT_W-1:0] pixel_x_q, pixel_y_q;

    always_comb begin
        h_sync_d      = (h_state == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
        v_sync_d      = (v_state == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
        active_d      = (h_state == ST_ACTIVE) && (v_state == ST_ACTIVE);
        line_start_d  = (h_count == '0);
        frame_start_d = (h_count == '0) && (v_count == '0);
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            h_sync_q      <= ~SYNC_POL;
            v_sync_q      <= ~SYNC_POL;
            active_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
        end else if (enable_i) begin
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            active_q      <= active_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            pixel_x_q     <= h_count;
            pixel_y_q     <= v_count;
        end
    end

    assign h_sync_pulse_o = h_sync_q;
    assign v_sync_pulse_o = v_sync_q;
    assign active_video_o = active_q;
    assign line_start_o   = line_start_q;
    assign frame_start_o  = frame_start_q;
    assign pixel_x_o      = pixel_x_q;
    assign pixel_y_o      = pixel_y_q;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// tb/tb_video_timing_ctrl.sv - randomized check of video_timing_ctrl against a raster model
module tb_video_timing_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        cfg = 1'b0;
    logic [10:0] rh  = '0;
    logic [10:0] rv  = '0;

    always #5 clk = ~clk;

    logic        hs0, vs0, av0, ls0, fs0;
    logic [11:0] px0, py0;
    logic        hs1, vs1, av1, ls1, fs1;
    logic [11:0] px1, py1;

    // Instance 0: 1080p defaults, active-high syncs
    video_timing_ctrl u_dut_def (
        .clock_i          (clk),
        .reset_i          (rst),
        .enable_i         (en),
        .res_horizontal_i (rh),
        .res_vertical_i   (rv),
        .cfg_update_i     (cfg),
        .h_sync_pulse_o   (hs0),
        .v_sync_pulse_o   (vs0),
        .active_video_o   (av0),
        .pixel_x_o        (px0),
        .pixel_y_o        (py0),
        .line_start_o     (ls0),
        .frame_start_o    (fs0)
    );

    // Instance 1: tiny raster so whole frames fit in the run, active-low syncs
    video_timing_ctrl #(
        .H_FP(3), .H_SYNC(2), .H_BP(4),
        .V_FP(2), .V_SYNC(2), .V_BP(3),
        .H_RES_DEF(16), .V_RES_DEF(8),
        .SYNC_POL(1'b0)
    ) u_dut_small (
        .clock_i          (clk),
        .reset_i          (rst),
        .enable_i         (en),
        .res_horizontal_i (rh),
        .res_vertical_i   (rv),
        .cfg_update_i     (cfg),
        .h_sync_pulse_o   (hs1),
        .v_sync_pulse_o   (vs1),
        .active_video_o   (av1),
        .pixel_x_o        (px1),
        .pixel_y_o        (py1),
        .line_start_o     (ls1),
        .frame_start_o    (fs1)
    );

    int hfp[2]  = '{88, 3};
    int hsw[2]  = '{44, 2};
    int hbp[2]  = '{148, 4};
    int vfp[2]  = '{4, 2};
    int vsw[2]  = '{5, 2};
    int vbp[2]  = '{36, 3};
    int hdef[2] = '{1920, 16};
    int vdef[2] = '{1080, 8};
    int pol[2]  = '{1, 0};

    // Model: position of the next pixel to present, applied/pending resolution
    int mx[2], my[2], mhr[2], mvr[2], mph[2], mpv[2];
    bit mpvld[2];
    int e_hs[2], e_vs[2], e_av[2], e_px[2], e_py[2], e_ls[2], e_fs[2];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit in_sync(int c, int res, int fp, int sw);
        return (c >= res + fp) && (c < res + fp + sw);
    endfunction

    function automatic int htot(int d);
        return mhr[d] + hfp[d] + hsw[d] + hbp[d];
    endfunction

    function automatic int vtot(int d);
        return mvr[d] + vfp[d] + vsw[d] + vbp[d];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mx[d] = 0; my[d] = 0;
            mhr[d] = hdef[d]; mvr[d] = vdef[d];
            mph[d] = 0; mpv[d] = 0; mpvld[d] = 1'b0;
            e_hs[d] = 1 - pol[d]; e_vs[d] = 1 - pol[d];
            e_av[d] = 0; e_px[d] = 0; e_py[d] = 0; e_ls[d] = 0; e_fs[d] = 0;
        end
    endtask

    task automatic model_step(input bit en_s, input bit cfg_s, input int rh_s, input int rv_s);
        for (int d = 0; d < 2; d++) begin
            if (cfg_s) begin
                mph[d] = rh_s; mpv[d] = rv_s; mpvld[d] = 1'b1;
            end
            if (en_s) begin
                e_px[d] = mx[d];
                e_py[d] = my[d];
                e_hs[d] = in_sync(mx[d], mhr[d], hfp[d], hsw[d]) ? pol[d] : 1 - pol[d];
                e_vs[d] = in_sync(my[d], mvr[d], vfp[d], vsw[d]) ? pol[d] : 1 - pol[d];
                e_av[d] = (mx[d] < mhr[d]) && (my[d] < mvr[d]);
                e_ls[d] = (mx[d] == 0);
                e_fs[d] = (mx[d] == 0) && (my[d] == 0);
                mx[d]++;
                if (mx[d] == htot(d)) begin
                    mx[d] = 0;
                    my[d]++;
                    if (my[d] == vtot(d)) begin
                        my[d] = 0;
                        if (mpvld[d]) begin
                            if (mph[d] != 0) mhr[d] = mph[d];
                            if (mpv[d] != 0) mvr[d] = mpv[d];
                            mpvld[d] = 1'b0;
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        check("d0_hsync", 32'(hs0), 32'(e_hs[0]));
        check("d0_vsync", 32'(vs0), 32'(e_vs[0]));
        check("d0_active", 32'(av0), 32'(e_av[0]));
        check("d0_px", 32'(px0), 32'(e_px[0]));
        check("d0_py", 32'(py0), 32'(e_py[0]));
        check("d0_line_start", 32'(ls0), 32'(e_ls[0]));
        check("d0_frame_start", 32'(fs0), 32'(e_fs[0]));
        check("d1_hsync", 32'(hs1), 32'(e_hs[1]));
        check("d1_vsync", 32'(vs1), 32'(e_vs[1]));
        check("d1_active", 32'(av1), 32'(e_av[1]));
        check("d1_px", 32'(px1), 32'(e_px[1]));
        check("d1_py", 32'(py1), 32'(e_py[1]));
        check("d1_line_start", 32'(ls1), 32'(e_ls[1]));
        check("d1_frame_start", 32'(fs1), 32'(e_fs[1]));
    endtask

    int freeze_cnt = 0;
    bit froze      = 1'b0;
    int wrap_cfgs  = 0;

    // One clock of stimulus: pick inputs at the falling edge, step the model on the
    // rising edge, compare at the next falling edge.
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            en  = ($urandom_range(0, 15) != 0);
            cfg = ($urandom_range(0, 199) == 0);
            rh  = 11'($urandom_range(0, 24));
            rv  = 11'($urandom_range(0, 14));
            if (!froze && mx[0] == 101 && my[0] == 1) begin
                freeze_cnt = 37;
                froze = 1'b1;
            end
            if (freeze_cnt > 0) begin
                en = 1'b0;
                freeze_cnt--;
            end else if (mx[1] == htot(1) - 1 && my[1] == vtot(1) - 1 && wrap_cfgs < 4) begin
                en  = 1'b1;
                cfg = 1'b1;
                if (wrap_cfgs == 0) rv = '0;
                wrap_cfgs++;
            end
            @(posedge clk);
            model_step(en, cfg, int'(rh), int'(rv));
            @(negedge clk);
            check_all();
        end
        cfg = 1'b0;
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        #12;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        run_cycles(9000);

        // Asynchronous reset in the middle of a line
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        check_all();
        @(negedge clk);
        rst = 1'b0;

        run_cycles(1500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
